serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 153 +++++++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are latched on a start request, added one bit
// per cycle LSB-first, and the sum, carry-out and signed overflow are
// published together with a one-cycle o_valid pulse.
module serial_adder #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [BUS_WIDTH-1:0] i_a,
  input  logic [BUS_WIDTH-1:0] i_b,
  input  logic                 i_cin,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [BUS_WIDTH-1:0] o_c,
  output logic                 o_cout,
  output logic                 o_ovf
);

  localparam int CNT_W = $clog2(BUS_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic [BUS_WIDTH-1:0] sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] c_q, c_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;

  logic load_s;
  logic step_s;
  logic last_s;
  logic sum_bit_s;
  logic carry_nxt_s;

  assign load_s      = (state_q == S_IDLE) && i_valid;
  assign step_s      = (state_q == S_BUSY);
  assign last_s      = step_s && (cnt_q == LAST_CNT);
  assign sum_bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt_s = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // State register and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: BUSY runs exactly BUS_WIDTH cycles regardless of operands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load on accept, one full-adder step per BUSY cycle,
  // and publish results on the final (MSB) step so they are valid in DONE.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (load_s) begin
      a_d     = i_a;
      b_d     = i_b;
      sum_d   = '0;
      carry_d = i_cin;
      cnt_d   = '0;
    end else if (step_s) begin
      a_d     = {1'b0, a_q[BUS_WIDTH-1:1]};
      b_d     = {1'b0, b_q[BUS_WIDTH-1:1]};
      sum_d   = {sum_bit_s, sum_q[BUS_WIDTH-1:1]};
      carry_d = carry_nxt_s;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_s) begin
        // carry_q here is the carry into the MSB; carry_nxt_s is the carry out.
        c_d    = {sum_bit_s, sum_q[BUS_WIDTH-1:1]};
        cout_d = carry_nxt_s;
        ovf_d  = carry_q ^ carry_nxt_s;
      end else begin
        c_d    = c_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
      end
    end else begin
      a_d = a_q;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      S_IDLE:  o_ready = 1'b1;
      S_BUSY:  o_ready = 1'b0;
      S_DONE:  o_valid = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  assign o_c    = c_q;
  assign o_cout = cout_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and table-driven checks for serial_adder at BUS_WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_c;
  logic         o_cout;
  logic         o_ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] c;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  serial_adder #(.BUS_WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(vin),
    .i_a    (a),
    .i_b    (b),
    .i_cin  (cin),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_c    (o_c),
    .o_cout (o_cout),
    .o_ovf  (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts one add at the current negedge and waits (bounded) for its result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                        input logic [7:0] ec, input logic ecout, input logic eovf,
                        input string tag);
    int n;
    bit seen;
    a = ta; b = tb2; cin = tc; vin = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      vin = 1'b0;
      if (o_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
    check({tag, "_c"}, 32'(o_c), 32'(ec));
    check({tag, "_cout"}, 32'(o_cout), 32'(ecout));
    check({tag, "_ovf"}, 32'(o_ovf), 32'(eovf));
    @(negedge clk);
    check({tag, "_pulse1"}, 32'(o_valid), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_hold"}, 32'(o_c), 32'(ec));
  endtask

  initial begin
    int         nready;
    int         npulse;
    int         n;
    bit         seen;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       qc[$];
    int         pulses;
    int         last_t;
    int         cyc;
    logic [8:0] gs;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ecn;
    bit         rdy;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_c", 32'(o_c), 32'd0);
    check("rst_cout", 32'(o_cout), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);

    // First request presented together with reset release.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].c, vecs[i].cout, vecs[i].ovf,
             $sformatf("vec%0d", i));
    end

    // Request during BUSY must be ignored; o_ready stays low until after DONE.
    a = 8'h12; b = 8'h34; cin = 1'b0; vin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    nready = 0; n = 1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i == 3) begin a = 8'hAA; b = 8'hAA; vin = 1'b1; end
      if (i == 4) begin vin = 1'b0; end
      if (o_ready) nready++;
      @(posedge clk);
      n++;
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    vin = 1'b0;
    check("busy_seen", 32'(seen), 32'd1);
    check("busy_latency", 32'(n), 32'(W + 1));
    check("busy_ready_low", 32'(nready), 32'd0);
    check("busy_c", 32'(o_c), 32'h46);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_valid) npulse++;
    end
    check("busy_ignored", 32'(npulse), 32'd0);

    // Reset on the 4th BUSY cycle aborts the add.
    a = 8'h55; b = 8'h11; cin = 1'b0; vin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_c", 32'(o_c), 32'd0);
    check("abort_cout", 32'(o_cout), 32'd0);
    check("abort_ovf", 32'(o_ovf), 32'd0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_valid) npulse++;
    end
    check("abort_nopulse", 32'(npulse), 32'd0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

    // i_valid held high over three operations with random operands.
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); vin = 1'b1;
    pulses = 0; last_t = -1; cyc = 0;
    for (int i = 0; i < 60 && pulses < 3; i++) begin
      rdy = o_ready;
      if (rdy) begin qa.push_back(a); qb.push_back(b); qc.push_back(cin); end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (rdy) begin a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); end
      if (o_valid) begin
        if (qa.size() > 0) begin
          ea = qa.pop_front(); eb = qb.pop_front(); ecn = qc.pop_front();
        end else begin
          ea = 8'h00; eb = 8'h00; ecn = 1'b0;
        end
        gs = {1'b0, ea} + {1'b0, eb} + {8'h00, ecn};
        check($sformatf("held%0d_c", pulses), 32'(o_c), 32'(gs[7:0]));
        check($sformatf("held%0d_cout", pulses), 32'(o_cout), 32'(gs[8]));
        check($sformatf("held%0d_ovf", pulses), 32'(o_ovf),
              32'((ea[7] == eb[7]) && (gs[7] != ea[7])));
        if (pulses > 0) check($sformatf("held%0d_period", pulses), 32'(cyc - last_t), 32'(W + 2));
        last_t = cyc;
        pulses++;
        if (pulses == 3) vin = 1'b0;
      end
    end
    vin = 1'b0;
    check("held_pulses", 32'(pulses), 32'd3);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
